// File: rtl/output_sram_arbiter.sv
// Round-robin arbiter in front of the output SRAM write port: grants one bank,
// takes its feature-vector burst and writes each beat at node_id*WORDS_PER_NODE + k.
module output_sram_arbiter #(
  parameter int NUM_BANKS      = 4,
  parameter int DATA_W         = 16,
  parameter int NODE_ID_W      = 10,
  parameter int WORDS_PER_NODE = 4,
  parameter int ADDR_W         = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BANKS-1:0]          bank_req,
  input  logic [NUM_BANKS-1:0]          bank_grant_valid,
  input  logic [NUM_BANKS-1:0]          bank_sos,
  input  logic [NUM_BANKS-1:0]          bank_eos,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_data,
  input  logic [NUM_BANKS*NODE_ID_W-1:0] bank_node_id,
  output logic [NUM_BANKS-1:0]          req_grant,
  output logic                          sram_wen,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [DATA_W-1:0]             sram_wdata,
  output logic                          busy,
  output logic                          overflow_err
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int WPN_W  = $clog2(WORDS_PER_NODE);
  localparam logic [WPN_W:0] WPN_CNT = (WPN_W+1)'(WORDS_PER_NODE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [BANK_W-1:0]    rr_ptr, winner, pick;
  logic                 pick_found;
  logic [WPN_W:0]       beat_idx, beat_k;
  logic [NODE_ID_W-1:0] node_lat, beat_node;
  logic [ADDR_W-1:0]    beat_addr;
  logic [NUM_BANKS-1:0] grant_next;
  logic                 accept, leave;
  logic                 sel_req, sel_valid, sel_sos, sel_eos;
  logic [DATA_W-1:0]    sel_data;
  logic [NODE_ID_W-1:0] sel_node;

  // First requester at or after rr_ptr, wrapping around the bank list.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick       = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_BANKS) idx = idx - NUM_BANKS;
      if (!pick_found && bank_req[BANK_W'(idx)]) begin
        pick_found = 1'b1;
        pick       = BANK_W'(idx);
      end
    end
  end

  always_comb begin
    sel_req   = 1'b0;
    sel_valid = 1'b0;
    sel_sos   = 1'b0;
    sel_eos   = 1'b0;
    sel_data  = '0;
    sel_node  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (winner == BANK_W'(i)) begin
        sel_req   = bank_req[i];
        sel_valid = bank_grant_valid[i];
        sel_sos   = bank_sos[i];
        sel_eos   = bank_eos[i];
        sel_data  = bank_data[i*DATA_W +: DATA_W];
        sel_node  = bank_node_id[i*NODE_ID_W +: NODE_ID_W];
      end
    end
  end

  // Next-state logic. A beat is accepted when the winner presents valid; in
  // GRANT it must also carry sos, later sos flags are ignored.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    leave      = 1'b0;
    grant_next = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          grant_next = NUM_BANKS'(1) << pick;
        end
      end
      GRANT: begin
        grant_next = req_grant;
        if (sel_valid && sel_sos) begin
          accept     = 1'b1;
          grant_next = '0;
          if (sel_eos) begin
            state_next = IDLE;
            leave      = 1'b1;
          end else begin
            state_next = STREAM;
          end
        end else if (!sel_req && !sel_valid) begin
          state_next = IDLE;
          leave      = 1'b1;
          grant_next = '0;
        end
      end
      STREAM: begin
        if (sel_valid) begin
          accept = 1'b1;
          if (sel_eos) begin
            state_next = IDLE;
            leave      = 1'b1;
          end
        end else begin
          state_next = IDLE;
          leave      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign beat_k    = (state == GRANT) ? '0 : beat_idx;
  assign beat_node = (state == GRANT) ? sel_node : node_lat;
  assign beat_addr = (ADDR_W'(beat_node) << WPN_W) | ADDR_W'(beat_k[WPN_W-1:0]);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_grant    <= '0;
      sram_wen     <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      overflow_err <= 1'b0;
      rr_ptr       <= '0;
      beat_idx     <= '0;
      winner       <= '0;
      node_lat     <= '0;
    end else begin
      sram_wen  <= 1'b0;
      req_grant <= grant_next;
      if (state == IDLE && pick_found) winner <= pick;
      if (leave) rr_ptr <= (winner == BANK_W'(NUM_BANKS-1)) ? '0 : winner + 1'b1;
      if (accept) begin
        if (state == GRANT) node_lat <= sel_node;
        if (beat_k < WPN_CNT) begin
          sram_wen   <= 1'b1;
          sram_addr  <= beat_addr;
          sram_wdata <= sel_data;
        end else begin
          overflow_err <= 1'b1;
        end
        // Saturating counter: past the node's window every beat keeps overflowing.
        beat_idx <= (beat_k == WPN_CNT) ? beat_k : beat_k + 1'b1;
      end
      if (state_next == IDLE) beat_idx <= '0;
    end
  end

endmodule

// File: tb/tb_output_sram_arbiter.sv
// Directed bench for output_sram_arbiter: grant order checked inline, SRAM
// writes checked against an expected queue filled as beats are driven.
module tb_output_sram_arbiter;
  localparam int NB = 4;
  localparam int DW = 16;
  localparam int NW = 10;
  localparam int AW = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic [NB-1:0]    bank_req, bank_grant_valid, bank_sos, bank_eos;
  logic [NB*DW-1:0] bank_data;
  logic [NB*NW-1:0] bank_node_id;
  logic [NB-1:0]    req_grant;
  logic             sram_wen;
  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    sram_wdata;
  logic             busy, overflow_err;

  logic [AW+DW-1:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  output_sram_arbiter dut (
    .clk(clk), .reset(reset),
    .bank_req(bank_req), .bank_grant_valid(bank_grant_valid),
    .bank_sos(bank_sos), .bank_eos(bank_eos),
    .bank_data(bank_data), .bank_node_id(bank_node_id),
    .req_grant(req_grant), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .busy(busy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Write monitor: every sram_wen must match the oldest expected write.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (sram_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        assert (exp_q.size() != 0) passed++;
        else $error("FAIL unexpected_write: got addr %0h data %0h expected none", sram_addr, sram_wdata);
      end else begin
        e = exp_q.pop_front();
        check("sram_write", 32'({sram_addr, sram_wdata}), 32'(e));
      end
    end
  end

  task automatic clear_inputs();
    bank_req = '0; bank_grant_valid = '0; bank_sos = '0; bank_eos = '0;
    bank_data = '0; bank_node_id = '0;
  endtask

  task automatic wait_grant(input string tag, input logic [NB-1:0] exp, output int cycles);
    cycles = 0;
    while (req_grant === '0 && cycles < 8) begin
      @(negedge clk);
      cycles++;
    end
    check(tag, 32'(req_grant), 32'(exp));
  endtask

  // Drives an n-beat burst from bank b; node_id is garbled after beat 0 so
  // the address must come from the latched value.
  task automatic send_burst(input int b, input int node, input int n, input logic [DW-1:0] base);
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = base + DW'(k) * 16'h0202;
      bank_grant_valid[b] = 1'b1;
      bank_sos[b] = (k == 0);
      bank_eos[b] = (k == n-1);
      bank_data[b*DW +: DW] = d;
      bank_node_id[b*NW +: NW] = (k == 0) ? NW'(node) : ~NW'(node);
      if (k < 4) exp_q.push_back({AW'(node*4 + k), d});
      @(negedge clk);
    end
    bank_grant_valid[b] = 1'b0; bank_sos[b] = 1'b0; bank_eos[b] = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_grant"}, 32'(req_grant), 0);
    check({tag, "_wen"},   32'(sram_wen), 0);
    check({tag, "_addr"},  32'(sram_addr), 0);
    check({tag, "_wdata"}, 32'(sram_wdata), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_ovf"},   32'(overflow_err), 0);
  endtask

  initial begin
    int cyc;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;

    // 2-beat burst from bank 1, node 5 -> addr 20, 21
    bank_req = 4'b0010;
    @(negedge clk);
    check("t1_grant_latency", 32'(req_grant), 32'(4'b0010));
    check("t1_busy", 32'(busy), 1);
    send_burst(1, 5, 2, 16'h0201);
    bank_req = '0;
    check("t1_busy_after", 32'(busy), 0);
    check("t1_grant_after", 32'(req_grant), 0);
    @(negedge clk);

    // restart with rr_ptr=0: banks 0 and 2 alternate
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bank_req = 4'b0101;
    for (int r = 0; r < 4; r++) begin
      wait_grant($sformatf("rr_grant%0d", r), (r % 2 == 0) ? 4'b0001 : 4'b0100, cyc);
      send_burst((r % 2 == 0) ? 0 : 2, 10 + r, 1, DW'(16'h3000 + r));
    end
    bank_req = '0;
    @(negedge clk);

    // abandon: rr_ptr=3 wraps to bank 0, which drops its request
    bank_req = 4'b0001;
    wait_grant("ab_grant", 4'b0001, cyc);
    bank_req = '0;
    @(negedge clk);
    check("ab_busy", 32'(busy), 0);
    check("ab_grant_clr", 32'(req_grant), 0);
    bank_req = 4'b1011;
    wait_grant("ab_rr_ptr1", 4'b0010, cyc);
    send_burst(1, 3, 1, 16'h4444);
    bank_req = '0;
    @(negedge clk);

    // wrap-around: bring rr_ptr to 3 via bank 2, then banks 0 and 3
    bank_req = 4'b0100;
    wait_grant("wr_setup", 4'b0100, cyc);
    send_burst(2, 20, 1, 16'h5555);
    bank_req = 4'b1001;
    wait_grant("wr_first", 4'b1000, cyc);
    send_burst(3, 21, 1, 16'h6666);
    bank_req = 4'b0001;
    wait_grant("wr_second", 4'b0001, cyc);
    send_burst(0, 22, 1, 16'h7777);
    bank_req = '0;
    @(negedge clk);

    // overflow: 6 beats for node 2 -> only addr 8..11 written
    check("ov_before", 32'(overflow_err), 0);
    bank_req = 4'b0010;
    wait_grant("ov_grant", 4'b0010, cyc);
    send_burst(1, 2, 6, 16'h1111);
    bank_req = '0;
    check("ov_set", 32'(overflow_err), 1);
    check("ov_busy", 32'(busy), 0);
    bank_req = 4'b0100;
    wait_grant("ov_grant2", 4'b0100, cyc);
    send_burst(2, 9, 1, 16'h8888);
    bank_req = '0;
    @(negedge clk);
    check("ov_sticky", 32'(overflow_err), 1);

    // reset after beat 1 of a 4-beat burst
    bank_req = 4'b0100;
    wait_grant("rs_grant", 4'b0100, cyc);
    bank_grant_valid[2] = 1'b1; bank_sos[2] = 1'b1;
    bank_data[2*DW +: DW] = 16'hA000; bank_node_id[2*NW +: NW] = 10'd7;
    exp_q.push_back({AW'(28), 16'hA000});
    @(negedge clk);
    bank_sos[2] = 1'b0; bank_req = '0;
    bank_data[2*DW +: DW] = 16'hA001;
    exp_q.push_back({AW'(29), 16'hA001});
    @(negedge clk);
    reset = 1'b1;
    bank_data[2*DW +: DW] = 16'hA002;
    @(negedge clk);
    check_reset_values("rs");
    reset = 1'b0;
    bank_data[2*DW +: DW] = 16'hA003; bank_eos[2] = 1'b1;
    repeat (2) @(negedge clk);
    check("rs_idle", 32'(busy), 0);
    clear_inputs();
    repeat (2) @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
